// File: rtl/inst_fetch_if.sv
// Byte-wide read port between the instruction fetcher and the memory arbiter.
// The fetcher drives the request and address; the arbiter returns grant and data.
interface inst_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_grant,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_grant,
    output mem_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetcher: reads four bytes through a byte-wide arbitrated port,
// assembles a little-endian word and holds it until IF/ID consumes it.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_flag,
  input  logic [31:0]  branch_target,
  inst_fetch_if.master mem,
  output logic [31:0]  inst_o,
  output logic [31:0]  pc_o,
  output logic         inst_valid
);

  typedef enum logic [2:0] {
    B0,
    B1,
    B2,
    B3,
    LAST,
    OUT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  byte_idx;
  logic        accept;

  // Lanes 0..2 only; byte 3 is taken straight from mem_rdata in LAST.
  logic [23:0] asm_q;
  logic        pend;
  logic [1:0]  pend_lane;

  // Branch targets are word-aligned, so the low two bits are ignored.
  logic        unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  always_comb begin
    state_next = state;
    req        = 1'b0;
    byte_idx   = 2'd0;
    case (state)
      B0: begin
        req      = 1'b1;
        byte_idx = 2'd0;
        if (mem.mem_grant) state_next = B1;
      end
      B1: begin
        req      = 1'b1;
        byte_idx = 2'd1;
        if (mem.mem_grant) state_next = B2;
      end
      B2: begin
        req      = 1'b1;
        byte_idx = 2'd2;
        if (mem.mem_grant) state_next = B3;
      end
      B3: begin
        req      = 1'b1;
        byte_idx = 2'd3;
        if (mem.mem_grant) state_next = LAST;
      end
      LAST: state_next = OUT;
      OUT:  if (!stall) state_next = B0;
      default: state_next = B0;
    endcase
    if (rst) req = 1'b0;
    addr   = req ? (fetch_pc + {30'b0, byte_idx}) : '0;
    accept = req && mem.mem_grant;
    if (branch_flag) state_next = B0;
  end

  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= B0;
      fetch_pc   <= RESET_PC;
      inst_o     <= '0;
      pc_o       <= '0;
      inst_valid <= 1'b0;
      asm_q      <= '0;
      pend       <= 1'b0;
      pend_lane  <= '0;
    end else begin
      state     <= state_next;
      // A redirect drops both the byte arriving now and the one just requested.
      pend      <= accept && !branch_flag;
      pend_lane <= byte_idx;
      if (branch_flag) begin
        fetch_pc   <= {branch_target[31:2], 2'b00};
        inst_valid <= 1'b0;
      end else begin
        if (pend) begin
          case (pend_lane)
            2'd0:    asm_q[7:0]   <= mem.mem_rdata;
            2'd1:    asm_q[15:8]  <= mem.mem_rdata;
            2'd2:    asm_q[23:16] <= mem.mem_rdata;
            default: ;
          endcase
        end
        if (state == LAST) begin
          inst_o     <= {mem.mem_rdata, asm_q};
          pc_o       <= fetch_pc;
          inst_valid <= 1'b1;
        end
        if (state == OUT && !stall) begin
          inst_valid <= 1'b0;
          fetch_pc   <= fetch_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural fetch model driven by directed scenarios
// and random grant/stall/branch/reset traffic against a synthetic byte memory.
module tb_inst_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned LOGN   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_valid;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .mem          (bus),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: current fetch address, bytes accepted so far, and whether a word is on the output.
  logic        m_init = 1'b0;
  logic [31:0] m_pc = '0;
  int          m_nacc = 0;
  logic        m_valid = 1'b0;
  logic        m_zero = 1'b0;
  logic        rd_valid = 1'b0;
  logic [7:0]  rd_byte = '0;

  logic [31:0] obs_req   [LOGN];
  logic [31:0] obs_addr  [LOGN];
  logic [31:0] obs_valid [LOGN];
  logic [31:0] obs_inst  [LOGN];
  logic [31:0] obs_pc    [LOGN];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ a[31:24] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    logic        exp_req;
    logic [31:0] exp_addr;
    if (cyc < LOGN) begin
      obs_req[cyc]   = {31'b0, bus.mem_req};
      obs_addr[cyc]  = bus.mem_addr;
      obs_valid[cyc] = {31'b0, inst_valid};
      obs_inst[cyc]  = inst_o;
      obs_pc[cyc]    = pc_o;
    end
    exp_req  = !rst && !m_valid && (m_nacc < 4);
    exp_addr = exp_req ? (m_pc + 32'(m_nacc)) : 32'd0;
    if (m_init) begin
      chk("mem_req", {31'b0, bus.mem_req}, {31'b0, exp_req});
      chk("mem_addr", bus.mem_addr, exp_addr);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
      if (m_valid) begin
        chk("inst_o", inst_o, word_at(m_pc));
        chk("pc_o", pc_o, m_pc);
      end else if (m_zero) begin
        chk("inst_o_rst", inst_o, 32'd0);
        chk("pc_o_rst", pc_o, 32'd0);
      end
    end
    rd_valid = exp_req && bus.mem_grant;
    rd_byte  = mem_byte(exp_addr);
    if (rst) begin
      m_pc = RST_PC; m_nacc = 0; m_valid = 1'b0; m_zero = 1'b1; m_init = 1'b1;
    end else if (branch_flag) begin
      m_pc = {branch_target[31:2], 2'b00}; m_nacc = 0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (!stall) begin
        m_valid = 1'b0; m_pc = m_pc + 32'd4; m_nacc = 0;
      end
    end else if (m_nacc == 4) begin
      m_valid = 1'b1; m_zero = 1'b0;
    end else if (rd_valid) begin
      m_nacc++;
    end
    cyc++;
  endtask

  // Inputs for one clock period; returned data is presented only after an accepted request.
  task automatic cycle(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic g);
    rst = r; stall = s; branch_flag = b; branch_target = t; bus.mem_grant = g;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    bus.mem_rdata = rd_valid ? rd_byte : 8'($urandom);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    int t0;
    logic g2 [12];
    logic s2 [12];
    g2 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    s2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bus.mem_grant = 1'b0;
    bus.mem_rdata = 8'h00;

    // Plain fetch of the word at 0 with continuous grant.
    do_reset();
    t0 = cyc;
    chk("rst_req", obs_req[t0-1], 32'd0);
    chk("rst_addr", obs_addr[t0-1], 32'd0);
    chk("rst_valid", obs_valid[t0-1], 32'd0);
    chk("rst_inst", obs_inst[t0-1], 32'd0);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("s1_req", obs_req[t0+i], 32'd1);
      chk("s1_addr", obs_addr[t0+i], 32'(i));
    end
    chk("s1_valid_early", obs_valid[t0+4], 32'd0);
    chk("s1_valid", obs_valid[t0+5], 32'd1);
    chk("s1_inst", obs_inst[t0+5], 32'h0010_0513);
    chk("s1_pc", obs_pc[t0+5], 32'd0);
    chk("s1_next_req", obs_req[t0+6], 32'd1);
    chk("s1_next_addr", obs_addr[t0+6], 32'd4);

    // Grant withheld two cycles in B2, then stalled three cycles in OUT.
    do_reset();
    t0 = cyc;
    for (int unsigned i = 0; i < 12; i++) cycle(1'b0, s2[i], 1'b0, 32'd0, g2[i]);
    for (int unsigned i = 2; i < 5; i++) begin
      chk("s2_req_hold", obs_req[t0+i], 32'd1);
      chk("s2_addr_hold", obs_addr[t0+i], 32'd2);
    end
    chk("s2_valid_early", obs_valid[t0+6], 32'd0);
    for (int unsigned i = 7; i < 11; i++) begin
      chk("s2_valid_held", obs_valid[t0+i], 32'd1);
      chk("s2_inst_held", obs_inst[t0+i], 32'h0010_0513);
      chk("s2_pc_held", obs_pc[t0+i], 32'd0);
    end
    chk("s2_consumed", obs_valid[t0+11], 32'd0);
    chk("s2_next_addr", obs_addr[t0+11], 32'd4);

    // Redirect to 0x1006 while in B2.
    do_reset();
    t0 = cyc;
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_1006, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("s3_target_addr", obs_addr[t0+3], 32'h0000_1004);
    for (int unsigned i = 0; i < 8; i++) chk("s3_no_valid", obs_valid[t0+i], 32'd0);
    chk("s3_valid", obs_valid[t0+8], 32'd1);
    chk("s3_pc", obs_pc[t0+8], 32'h0000_1004);
    chk("s3_inst", obs_inst[t0+8], word_at(32'h0000_1004));

    // Branch together with stall in OUT, then reset while in B3.
    do_reset();
    t0 = cyc;
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("s4_valid_out", obs_valid[t0+5], 32'd1);
    chk("s4_branch_valid", obs_valid[t0+6], 32'd0);
    chk("s4_branch_addr", obs_addr[t0+6], 32'h0000_2000);
    chk("s4_b3_addr", obs_addr[t0+8], 32'h0000_2002);
    chk("s4_rst_req", obs_req[t0+9], 32'd0);
    chk("s4_rst_addr", obs_addr[t0+9], 32'd0);
    chk("s4_after_inst", obs_inst[t0+10], 32'd0);
    chk("s4_after_pc", obs_pc[t0+10], 32'd0);
    chk("s4_after_valid", obs_valid[t0+10], 32'd0);
    chk("s4_refetch_req", obs_req[t0+10], 32'd1);
    chk("s4_refetch_addr", obs_addr[t0+10], 32'd0);

    // Random traffic against the model.
    for (int unsigned n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 99) < 1),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 5),
            $urandom,
            ($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have a single clock and a single reset; reset SHALL be synchronous and active-high.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port stall, input, 1 bit: downstream (IF/ID) cannot accept the presented instruction.
REQ-006 Port branch_flag, input, 1 bit: one-cycle redirect request from EX.
REQ-007 Port branch_target, input, 32 bits: redirect address, valid when branch_flag=1.
REQ-008 Port mem_req, output, 1 bit: byte-read request to the memory arbiter.
REQ-009 Port mem_addr, output, 32 bits: byte address of the request.
REQ-010 Port mem_grant, input, 1 bit: the arbiter accepts mem_req this cycle.
REQ-011 Port mem_rdata, input, 8 bits: read byte, valid the cycle after an accepted request.
REQ-012 Port inst_o, output, 32 bits: assembled little-endian instruction.
REQ-013 Port pc_o, output, 32 bits: address of inst_o.
REQ-014 Port inst_valid, output, 1 bit: inst_o and pc_o are valid.

Function
REQ-015 The FSM SHALL have states B0, B1, B2, B3, LAST and OUT.
REQ-016 In Bi (i=0..3), mem_req SHALL be 1 and mem_addr SHALL be fetch_pc+i.
REQ-017 In LAST and OUT, mem_req SHALL be 0 and mem_addr SHALL be 0.
REQ-018 A request is accepted when mem_req=1 and mem_grant=1 in the same cycle.
REQ-019 On an accepted request in Bi, the state SHALL advance to B(i+1), with B3 advancing to LAST.
REQ-020 Without a grant, the state SHALL hold and the same address SHALL be re-presented.
REQ-021 In the cycle after an accepted request for byte i, mem_rdata SHALL be written into lane i (bits 8i+7:8i) of the assembly register, independent of the current grant.
REQ-022 In LAST, the byte-3 capture SHALL occur, inst_o SHALL be loaded as {b3,b2,b1,b0}, pc_o SHALL be loaded with fetch_pc, and inst_valid SHALL be set; the state then moves to OUT.
REQ-023 In OUT with stall=0, the instruction SHALL be consumed: inst_valid SHALL be cleared next cycle, fetch_pc SHALL become fetch_pc+4 (modulo 2^32), and the state SHALL return to B0.
REQ-024 In OUT with stall=1, inst_o, pc_o and inst_valid=1 SHALL be held unchanged for as long as stall remains 1.
REQ-025 With continuous grant and no stall, the first request SHALL be at cycle t, inst_valid SHALL be 1 at t+5, and the next request SHALL be at t+6.
REQ-026 stall SHALL have no effect in states B0..LAST.
REQ-027 When branch_flag=1 in any state, the next cycle SHALL have fetch_pc = {branch_target[31:2],2'b00}, state B0 and inst_valid=0; any in-flight byte SHALL be discarded and not written.
REQ-028 branch_flag SHALL take priority over stall and over completion in LAST and OUT.
REQ-029 When rst and branch_flag are both 1, rst SHALL win.
REQ-030 inst_valid SHALL never be 1 for an instruction containing a byte captured before the most recent redirect.

Reset
REQ-031 When rst=1 at a clock edge, the next cycle SHALL have state B0, fetch_pc=RESET_PC, inst_o=0, pc_o=0, inst_valid=0, the assembly register cleared and in-flight flags cleared.
REQ-032 While rst=1, mem_req SHALL be 0 and mem_addr SHALL be 0.
REQ-033 The first request SHALL be issued in the first cycle with rst=0.
REQ-034 Reset asserted mid-fetch SHALL abandon the fetch without capturing the returning byte.

Verification
REQ-035 Memory 0..3 = 13 05 10 00, grant always 1: requests at addresses 0,1,2,3 in consecutive cycles; inst_valid=1 five cycles after the first request with inst_o=32'h00100513 and pc_o=0; the next request is to address 4.
REQ-036 Same image, grant low for 2 cycles while in B2: address 2 is presented for 3 cycles; byte 1 is still captured; the result is unchanged at 32'h00100513 with completion delayed by 2 cycles.
REQ-037 stall=1 for 3 cycles in OUT: inst_o, pc_o and inst_valid=1 are held for 4 cycles; exactly one pc advance to 4 occurs after stall falls.
REQ-038 branch_flag=1 with branch_target=32'h0000_1006 in B2: the next request is to 32'h0000_1004; no inst_valid is produced for pc 0; the bytes returned later assemble the word at 0x1004.
REQ-039 branch_flag=1 together with stall=1 in OUT: inst_valid=0 next cycle; the fetch restarts at the target.
REQ-040 rst pulse in B3: all outputs are zero next cycle; refetch starts at RESET_PC=0.
